mem_io_ctrl: RTL

- Memory/IO bus controller directly downstream of the lab 7 CPU datapath inside lab7_top.
- Takes the CPU's mem_cmd/mem_addr/write_data requests. Steers them to the 256-word synchronous RAM, the LED register, the HEX value register or the switch input.
- Returns read_data with a one-cycle mem_ready handshake.
- Replaces the ad-hoc tri-state/compare glue in the top level with one clocked, verifiable block.

---
 rtl/mem_io_ctrl_pkg.sv | 31 +++
 rtl/mem_io_ctrl_if.sv | 27 ++
 rtl/mem_io_ctrl_sync2.sv | 28 ++
 rtl/mem_io_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/mem_io_ctrl_pkg.sv
// Shared definitions for the lab 7 memory/IO controller: CPU bus command
// encodings, controller FSM states and the memory-mapped IO addresses that
// lab7_top and the CPU also rely on.
package mem_io_ctrl_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int RAM_AW = 8;

    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] HEX_ADDR = 9'h120;
    localparam logic [8:0] SW_ADDR  = 9'h140;

    // 2'b11 is deliberately not listed; the controller treats it as NONE.
    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    function automatic logic is_req(input logic [1:0] cmd);
        return (cmd == MEM_READ) || (cmd == MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_io_ctrl_if.sv
// CPU-side request/response bus of the memory/IO controller.
//   mem_cmd, mem_addr, write_data : CPU -> controller request
//   read_data, mem_ready, bus_err : controller -> CPU completion
// master = CPU side, slave = controller side.
interface mem_io_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) ();

    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              mem_ready;
    logic              bus_err;

    modport master (
        output mem_cmd, mem_addr, write_data,
        input  read_data, mem_ready, bus_err
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data,
        output read_data, mem_ready, bus_err
    );

endinterface

// File: rtl/mem_io_ctrl_sync2.sv
// Two-flop synchronizer (sync2) for bringing asynchronous level inputs
// into the clk domain.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flop stages
//   d     : asynchronous input
//   q     : synchronized output, two edges behind d
module mem_io_ctrl_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mem_io_ctrl.sv
// Memory/IO bus controller between the lab 7 CPU and its RAM / IO.
// A request accepted in IDLE is latched, executed in ACCESS and
// acknowledged with a single-cycle mem_ready in RESP.
//   clk, reset_n   : clock, asynchronous active-low reset
//   bus (slave)    : mem_cmd/mem_addr/write_data in,
//                    read_data/mem_ready/bus_err out
//   ram_addr/ram_write/ram_din/ram_dout : 256-word synchronous RAM port
//   sw_in          : raw switches (asynchronous)
//   led_out        : LED register (LED_ADDR)
//   hex_val        : HEX display value register (HEX_ADDR)
module mem_io_ctrl #(
    parameter int               ADDR_W   = mem_io_ctrl_pkg::ADDR_W,
    parameter int               DATA_W   = mem_io_ctrl_pkg::DATA_W,
    parameter int               RAM_AW   = mem_io_ctrl_pkg::RAM_AW,
    parameter logic [ADDR_W-1:0] LED_ADDR = mem_io_ctrl_pkg::LED_ADDR,
    parameter logic [ADDR_W-1:0] HEX_ADDR = mem_io_ctrl_pkg::HEX_ADDR,
    parameter logic [ADDR_W-1:0] SW_ADDR  = mem_io_ctrl_pkg::SW_ADDR
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_io_ctrl_if.slave      bus,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic [7:0]        sw_in,
    output logic [7:0]        led_out,
    output logic [DATA_W-1:0] hex_val
);

    import mem_io_ctrl_pkg::*;

    state_e            state, state_nxt;
    logic [1:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [7:0]        sw_sync;
    logic [DATA_W-1:0] rdata;

    logic ram_sel, led_sel, hex_sel, sw_sel;
    logic is_wr, is_rd, addr_err;

    mem_io_ctrl_sync2 #(.WIDTH(8)) u_sw_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (sw_in),
        .q     (sw_sync)
    );

    // State register plus request capture; inputs are only looked at in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            cmd_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && is_req(bus.mem_cmd)) begin
                cmd_q  <= bus.mem_cmd;
                addr_q <= bus.mem_addr;
                data_q <= bus.write_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (is_req(bus.mem_cmd)) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Decode from the latched address only; full-width compares, no aliasing.
    always_comb begin
        ram_sel  = ~addr_q[ADDR_W-1];
        led_sel  = (addr_q == LED_ADDR);
        hex_sel  = (addr_q == HEX_ADDR);
        sw_sel   = (addr_q == SW_ADDR);
        is_wr    = (cmd_q == MEM_WRITE);
        is_rd    = (cmd_q == MEM_READ);
        addr_err = !(ram_sel || led_sel || hex_sel || sw_sel) || (is_wr && sw_sel);
    end

    // IO register writes land on the ACCESS->RESP edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out <= '0;
            hex_val <= '0;
        end else if (state == ST_ACCESS && is_wr) begin
            if (led_sel) led_out <= data_q[7:0];
            if (hex_sel) hex_val <= data_q;
        end
    end

    assign ram_addr  = addr_q[RAM_AW-1:0];
    assign ram_din   = data_q;
    assign ram_write = (state == ST_ACCESS) && is_wr && ram_sel;

    // RAM data arrives one cycle after the address, which lines up with RESP,
    // so the read mux is combinational rather than registered.
    always_comb begin
        rdata = '0;
        if (ram_sel)      rdata = ram_dout;
        else if (led_sel) rdata = DATA_W'(led_out);
        else if (hex_sel) rdata = hex_val;
        else if (sw_sel)  rdata = DATA_W'(sw_sync);
    end

    assign bus.mem_ready = (state == ST_RESP);
    assign bus.bus_err   = (state == ST_RESP) && addr_err;
    assign bus.read_data = ((state == ST_RESP) && is_rd) ? rdata : '0;

endmodule
